ser_lane_array: RTL and testbench



---
 rtl/ser_lane_array.sv | 115 +++++++++++
 tb/tb_ser_lane_array.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_lane_array.sv
// Multi-lane serializer: a shared word counter loads every lane on one edge, and each lane
// emits data, a clock pattern, PRBS7 or zero through a chain of delayed, invertible taps.
module ser_lane_array #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned WORD_WIDTH = 20,
  parameter int unsigned NUM_TAPS   = 3,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_LANES-1:0]               EN_LANE,
  input  logic [NUM_LANES*WORD_WIDTH-1:0]    DATA,
  input  logic [NUM_LANES-1:0]               DATA_VALID,
  input  logic [2*NUM_LANES-1:0]             SEL_OUT,
  input  logic [(NUM_TAPS-1)*NUM_LANES-1:0]  EN_TAP,
  input  logic [(NUM_TAPS-1)*NUM_LANES-1:0]  INV_TAP,
  output logic                               WORD_STB,
  output logic [NUM_LANES-1:0]               UNDERFLOW,
  output logic [NUM_TAPS*NUM_LANES-1:0]      TAP
);

  localparam int unsigned CntW = $clog2(WORD_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_WIDTH - 1);

  localparam logic [1:0] ModeClk  = 2'd0;
  localparam logic [1:0] ModeData = 2'd1;
  localparam logic [1:0] ModePrbs = 2'd2;

  logic [CntW-1:0] cnt_q;
  logic            load;

  // The last bit cycle of a word doubles as the load strobe for every lane.
  assign load     = (cnt_q == CntLast);
  assign WORD_STB = load;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic                  en;
    logic [1:0]            mode;
    logic                  src;
    logic [WORD_WIDTH-1:0] sr_q;
    logic                  tgl_q;
    logic [6:0]            prbs_q;
    logic [NUM_TAPS-1:0]   tap_q;
    logic                  uf_q;

    assign en   = EN_LANE[l];
    assign mode = SEL_OUT[2*l +: 2];

    always_comb begin
      src = 1'b0;
      if (en) begin
        unique case (mode)
          ModeClk:  src = tgl_q;
          ModeData: src = sr_q[0];
          ModePrbs: src = prbs_q[6];
          default:  src = 1'b0;
        endcase
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sr_q   <= '0;
        tgl_q  <= 1'b0;
        prbs_q <= '0;
        tap_q  <= '0;
        uf_q   <= 1'b0;
      end else begin
        // The shift register loads regardless of mode so a mode switch stays word aligned.
        if (load) begin
          if (!en) begin
            sr_q <= '0;
          end else if (DATA_VALID[l]) begin
            sr_q <= DATA[l*WORD_WIDTH +: WORD_WIDTH];
          end else begin
            sr_q <= IDLE_WORD;
          end
        end else begin
          sr_q <= sr_q >> 1;
        end

        if (en) begin
          tgl_q <= ~tgl_q;
        end

        // XNOR feedback: all-ones is the lock-up state, unreachable from the zero seed.
        if (en && (mode == ModePrbs)) begin
          prbs_q <= {prbs_q[5:0], ~(prbs_q[6] ^ prbs_q[5])};
        end

        uf_q <= load && en && (mode == ModeData) && !DATA_VALID[l];

        tap_q[0] <= src;
        for (int k = 1; k < NUM_TAPS; k++) begin
          tap_q[k] <= EN_TAP[l*(NUM_TAPS-1) + k - 1]
                    ? (tap_q[k-1] ^ INV_TAP[l*(NUM_TAPS-1) + k - 1]) : 1'b0;
        end
      end
    end

    assign TAP[l*NUM_TAPS +: NUM_TAPS] = tap_q;
    assign UNDERFLOW[l]                = uf_q;
  end

endmodule

// File: tb/tb_ser_lane_array.sv
// Scoreboard bench for ser_lane_array: a word-level reference model queues expected outputs,
// and a negedge monitor compares them against the DUT every cycle.
module tb_ser_lane_array;

  localparam int unsigned NL = 4;
  localparam int unsigned WW = 20;
  localparam int unsigned NT = 3;
  localparam logic [WW-1:0] IDLE = 20'h3C3C3;

  logic                   clk;
  logic                   rst;
  logic [NL-1:0]          en_lane;
  logic [NL*WW-1:0]       data;
  logic [NL-1:0]          data_valid;
  logic [2*NL-1:0]        sel_out;
  logic [(NT-1)*NL-1:0]   en_tap;
  logic [(NT-1)*NL-1:0]   inv_tap;
  logic                   word_stb;
  logic [NL-1:0]          underflow;
  logic [NT*NL-1:0]       tap;

  ser_lane_array #(
    .NUM_LANES (NL),
    .WORD_WIDTH(WW),
    .NUM_TAPS  (NT),
    .IDLE_WORD (IDLE)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN_LANE   (en_lane),
    .DATA      (data),
    .DATA_VALID(data_valid),
    .SEL_OUT   (sel_out),
    .EN_TAP    (en_tap),
    .INV_TAP   (inv_tap),
    .WORD_STB  (word_stb),
    .UNDERFLOW (underflow),
    .TAP       (tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             stb;
    logic [NL-1:0]    uf;
    logic [NT*NL-1:0] tap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   run = 1'b0;
  int   cyc = 0;

  // Reference model state: word in flight is indexed by the bit position, not shifted.
  logic            prbs_tab[127];
  int              m_cnt;
  logic [WW-1:0]   m_word[NL];
  logic            m_t[NL];
  int              m_padv[NL];
  logic [NT-1:0]   m_tap[NL];
  logic [NL-1:0]   m_uf;

  always @(posedge clk) cyc <= cyc + 1;

  // After n advances from the zero seed, the MSB holds the bit generated n-7 advances ago.
  function automatic logic prbs_bit(input int n);
    return (n < 7) ? 1'b0 : prbs_tab[(n - 7) % 127];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.stb = (m_cnt == WW - 1);
    e.uf  = m_uf;
    e.tap = '0;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NT; k++) e.tap[l*NT + k] = m_tap[l][k];
    return e;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_uf  = '0;
    for (int l = 0; l < NL; l++) begin
      m_word[l] = '0;
      m_t[l]    = 1'b0;
      m_padv[l] = 0;
      m_tap[l]  = '0;
    end
  endtask

  task automatic model_step();
    bit         stb;
    bit         en;
    logic [1:0] mode;
    logic       src;
    stb = (m_cnt == WW - 1);
    for (int l = 0; l < NL; l++) begin
      en   = en_lane[l];
      mode = sel_out[2*l +: 2];
      src  = 1'b0;
      if (en) begin
        case (mode)
          2'd0:    src = m_t[l];
          2'd1:    src = m_word[l][m_cnt];
          2'd2:    src = prbs_bit(m_padv[l]);
          default: src = 1'b0;
        endcase
      end
      for (int k = NT - 1; k >= 1; k--)
        m_tap[l][k] = en_tap[l*(NT-1) + k - 1] ? (m_tap[l][k-1] ^ inv_tap[l*(NT-1) + k - 1])
                                                : 1'b0;
      m_tap[l][0] = src;
      m_uf[l] = stb && en && (mode == 2'd1) && !data_valid[l];
      if (stb) m_word[l] = !en ? '0 : (data_valid[l] ? data[l*WW +: WW] : IDLE);
      if (en) m_t[l] = ~m_t[l];
      if (en && mode == 2'd2) m_padv[l]++;
    end
    m_cnt = (m_cnt + 1) % WW;
  endtask

  task automatic randomize_inputs();
    for (int l = 0; l < NL; l++) begin
      data[l*WW +: WW] = WW'($urandom);
      data_valid[l]    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) en_lane[l] = ~en_lane[l];
      if ($urandom_range(0, 39) == 0) sel_out[2*l +: 2] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < (NT-1)*NL; i++) begin
      if ($urandom_range(0, 49) == 0) en_tap[i]  = ~en_tap[i];
      if ($urandom_range(0, 49) == 0) inv_tap[i] = ~inv_tap[i];
    end
  endtask

  // Called at posedge+1: set this cycle's inputs, queue the next cycle's outputs.
  task automatic step(input bit rnd);
    if (rnd) randomize_inputs();
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    vectors++;
    if (word_stb !== 1'b0 || underflow !== '0 || tap !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs t=%0t stb=%b uf=%h tap=%h, required all zero",
               $time, word_stb, underflow, tap);
    end
  endtask

  task automatic release_reset();
    rst = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    run = 1'b1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset();
    end
    release_reset();
  endtask

  always @(negedge clk) begin
    if (run) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry, required one", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({word_stb, underflow, tap} !== mon_e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: stb got %b exp %b, uf got %h exp %h, tap got %h exp %h",
                   cyc, word_stb, mon_e.stb, underflow, mon_e.uf, tap, mon_e.tap);
        end
      end
    end
  end

  initial begin
    logic [6:0] p;
    p = '0;
    for (int j = 0; j < 127; j++) begin
      prbs_tab[j] = ~(p[6] ^ p[5]);
      p = {p[5:0], prbs_tab[j]};
    end

    rst        = 1'b1;
    en_lane    = 4'hF;
    data       = '0;
    data[0 +: WW]  = 20'hA5F01;
    data[WW +: WW] = 20'h12345;
    data_valid = 4'b0001;
    sel_out    = 8'h25;   // lane0 data, lane1 data, lane2 PRBS, lane3 clock
    en_tap     = 8'hFD;   // lane0: tap1 on, tap2 off
    inv_tap    = 8'h01;   // lane0: tap1 inverted

    #1;
    check_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset();
    end
    release_reset();

    // Directed: data ordering, underflow with idle word, PRBS over two periods, clock pattern.
    repeat (270) step(1'b0);

    // Lane 3 to zero mode mid-word.
    while (m_cnt != 7) step(1'b0);
    sel_out[7:6] = 2'b11;
    repeat (30) step(1'b0);

    // Lane 1 in PRBS mode with no valid data must not underflow.
    sel_out[3:2] = 2'b10;
    repeat (60) step(1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat (400 + $urandom_range(0, 37)) step(1'b1);
      do_reset();
    end
    repeat (300) step(1'b1);

    @(negedge clk);
    #1;
    run = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
